pir_input_conditioner: RTL and testbench
========================================

# pir_input_conditioner

Front-end stage for the motion-detection datapath, sitting directly upstream of the alarm controller. It synchronizes and debounces the three raw PIR sensor lines and gates them with the system enable `turn`. After enable it applies a sensor warm-up lockout, then converts debounced rising edges into per-zone motion events. Events are held in a pending mask and delivered to the alarm controller over a valid/ready handshake, so no event is lost while the controller is busy.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized input must disagree with the debounced level before that level toggles. Legal range ≥ 1.
- `WARMUP_CYCLES`, default 8: lockout length after `turn` rises. Legal range ≥ 1.
- `clk` in 1: single system clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `turn` in 1: system enable, synchronous to `clk`. 1 = on.
- `pir_sensor_1`, `pir_sensor_2`, `pir_sensor_3` in 1 each: raw asynchronous PIR inputs. 1 = motion.
- `motion_ready` in 1: alarm controller accepts the pending event.
- `motion_valid` out 1: pending event mask is non-zero.
- `motion_zone` out 3: pending event mask. Bit 0 = sensor 1, bit 1 = sensor 2, bit 2 = sensor 3.
- `motion_level` out 3: debounced sensor levels. Zeroed when not ARMED.
- `zone_count` out 2: population count of `motion_level`, range 0–3.
- `armed` out 1: state == ARMED.

## Operation
- **Synchronizer:** two-flop synchronizer per sensor (`s1`, `s2`). It runs in all states except reset.
- **Debouncer:** one per sensor, counter width $clog2(DEBOUNCE_CYCLES).
  - If `s2` != level and cnt == DEBOUNCE_CYCLES-1: toggle level, clear cnt.
  - Else if `s2` != level: cnt+1.
  - Else: clear cnt.
  - A disagreement shorter than DEBOUNCE_CYCLES never toggles the level.
- **FSM states:** OFF, WARMUP, ARMED.
  - OFF: debounce levels, counters and pending mask are held at 0. `turn`=1 → WARMUP, with the warm-up counter cleared.
  - WARMUP: the warm-up counter increments. Debouncers run, but rising edges do not set pending bits. When counter == WARMUP_CYCLES-1 → ARMED.
  - ARMED: a debounced 0→1 toggle on sensor i sets `pending[i]`. Falling toggles set nothing.
  - In any state, `turn`=0 → OFF on the next edge. Levels, counters, pending mask and synchronizer contents other than raw sampling are cleared.
- **Level-only sensors:** a sensor whose debounced level is already 1 on entering ARMED generates no event until it falls and rises again.
- **Pending mask update in ARMED, per edge:** pending_next = (`motion_valid` & `motion_ready` ? 0 : pending) | new_rise_mask.
- **Simultaneous events:** a rise in the same cycle as an accepted handshake survives into the next mask. Repeated rises on an already-pending bit merge; there is no counting.
- `motion_ready` is ignored when `motion_valid`=0.
- **Reset:** `rst_n`=0 sampled at an edge gives state OFF, clears every register, and makes all outputs 0. Reset overrides `turn` and may occur mid-operation in any state.

## Timing
- **Reset values:** `motion_valid`=0, `motion_zone`=3'b000, `motion_level`=3'b000, `zone_count`=0, `armed`=0.
- **Input latency:** suppose a raw input first sampled high at edge k (into `s1`) and held high.
  - `s2` is high after edge k+1.
  - `motion_level` bit is high after edge k+1+DEBOUNCE_CYCLES, which is k+5 at default.
  - `motion_zone` bit and `motion_valid` are high after the same edge.
- **Arming latency:** `turn` sampled high at edge w enters WARMUP. `armed`=1 after edge w+WARMUP_CYCLES.
- **Handshake:** `motion_valid` drops after the edge at which `motion_valid`&`motion_ready`=1, unless a same-cycle rise occurred. It holds indefinitely while `motion_ready`=0.
- **Derived outputs:** `zone_count` and `armed` are registered-state derived and combinational from registers only. No output depends combinationally on `motion_ready`.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 edges with `turn`=1 and all sensors=1. Required: all outputs 0 throughout and `armed`=0. Release reset: `armed`=1 exactly 9 edges later.
2. **Warm-up lockout:** `turn`=1 at edge w with sensors 1 and 3 high from w. Required: `armed`=1 after w+8, `motion_level`=3'b101, and `motion_valid` stays 0.
3. **Glitch rejection:** in ARMED, pulse sensor 2 high for 3 cycles. Required: `motion_level` and `motion_valid` unchanged. Then hold it high from edge k: `motion_level`=3'b010, `motion_zone`=3'b010, `motion_valid`=1 after k+5.
4. **Accumulation and handshake:** with `motion_ready`=0, sensor 1 rises, then sensor 3 rises 10 cycles later. Required: `motion_zone`=3'b101 and `zone_count`=2. Pulse `motion_ready` for 1 cycle: `motion_valid`=0 next edge.
5. **Simultaneous rise and ack:** arrange for sensor 2's debounced rise to land on the ack edge. Required: after that edge `motion_zone`=3'b010 and `motion_valid` remains 1.
6. **Enable drop mid-operation:** with `motion_valid`=1 and `zone_count`=3, drop `turn` for one cycle. Required: next edge all outputs 0. Re-raise `turn`: `armed` returns only after a full 8-edge warm-up, with no event for sensors still high.

Source files
------------

// File: rtl/pir_input_conditioner.sv
// PIR sensor front end: synchronize, debounce, warm-up lockout, and
// per-zone rising-edge events held pending until the alarm controller accepts them.
module pir_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WARMUP_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       turn,
    input  logic       pir_sensor_1,
    input  logic       pir_sensor_2,
    input  logic       pir_sensor_3,
    input  logic       motion_ready,
    output logic       motion_valid,
    output logic [2:0] motion_zone,
    output logic [2:0] motion_level,
    output logic [1:0] zone_count,
    output logic       armed
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WARMUP = 2'd1,
        ARMED  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]         s1, s2;
    logic [2:0]         level, level_next;
    logic [2:0][DW-1:0] cnt, cnt_next;
    logic [WW-1:0]      wcnt, wcnt_next;
    logic [2:0]         pending, pending_next;

    logic [2:0]         deb_level;
    logic [2:0][DW-1:0] deb_cnt;
    logic [2:0]         tog;
    logic [2:0]         rise;
    logic               ack;

    // Free-running debounce result; the FSM decides whether it is used.
    always_comb begin
        deb_level = level;
        deb_cnt   = cnt;
        tog       = '0;
        for (int i = 0; i < 3; i++) begin
            if (s2[i] != level[i]) begin
                if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_level[i] = ~level[i];
                    deb_cnt[i]   = '0;
                    tog[i]       = 1'b1;
                end else begin
                    deb_cnt[i] = cnt[i] + 1'b1;
                end
            end else begin
                deb_cnt[i] = '0;
            end
        end
    end

    assign rise = tog & ~level;
    assign ack  = motion_valid & motion_ready;

    always_comb begin
        state_next   = state;
        level_next   = level;
        cnt_next     = cnt;
        wcnt_next    = wcnt;
        pending_next = pending;
        unique case (state)
            OFF: begin
                level_next   = '0;
                cnt_next     = '0;
                pending_next = '0;
                wcnt_next    = '0;
                if (turn) state_next = WARMUP;
            end
            WARMUP: begin
                level_next = deb_level;
                cnt_next   = deb_cnt;
                if (wcnt == WW'(WARMUP_CYCLES - 1)) begin
                    state_next = ARMED;
                end else begin
                    wcnt_next = wcnt + 1'b1;
                end
            end
            ARMED: begin
                level_next   = deb_level;
                cnt_next     = deb_cnt;
                pending_next = (ack ? 3'b000 : pending) | rise;
            end
            default: begin
                state_next = OFF;
            end
        endcase
        if (!turn) begin
            state_next   = OFF;
            level_next   = '0;
            cnt_next     = '0;
            wcnt_next    = '0;
            pending_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OFF;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            level   <= '0;
            cnt     <= '0;
            wcnt    <= '0;
            pending <= '0;
        end else begin
            s1      <= {pir_sensor_3, pir_sensor_2, pir_sensor_1};
            s2      <= s1;
            level   <= level_next;
            cnt     <= cnt_next;
            wcnt    <= wcnt_next;
            pending <= pending_next;
        end
    end

    assign armed        = (state == ARMED);
    assign motion_valid = |pending;
    assign motion_zone  = pending;
    assign motion_level = armed ? level : 3'b000;
    assign zone_count   = 2'(motion_level[0]) + 2'(motion_level[1])
                        + 2'(motion_level[2]);

endmodule

// File: tb/tb_pir_input_conditioner.sv
// Bench for pir_input_conditioner: per-cycle reference model comparison
// plus directed scenarios with literal expectations.
module tb_pir_input_conditioner;

    localparam int DEB  = 4;
    localparam int WARM = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       turn;
    logic       pir_sensor_1, pir_sensor_2, pir_sensor_3;
    logic       motion_ready;
    logic       motion_valid;
    logic [2:0] motion_zone;
    logic [2:0] motion_level;
    logic [1:0] zone_count;
    logic       armed;

    int checks = 0;
    int errors = 0;

    pir_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .WARMUP_CYCLES  (WARM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .turn        (turn),
        .pir_sensor_1(pir_sensor_1),
        .pir_sensor_2(pir_sensor_2),
        .pir_sensor_3(pir_sensor_3),
        .motion_ready(motion_ready),
        .motion_valid(motion_valid),
        .motion_zone (motion_zone),
        .motion_level(motion_level),
        .zone_count  (zone_count),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sensors seen two edges late, a level flips after
    // DEB consecutive disagreeing samples, events only in the armed phase.
    bit         model_ok = 0;
    bit   [2:0] m_s1, m_s2, m_lvl, m_pend, m_rise;
    int         m_run [3];
    int         m_st;
    int         m_wc;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pend = 0;
            m_run = '{0, 0, 0};
            m_st = 0; m_wc = 0;
            model_ok = 1;
        end else begin
            if (!turn) begin
                m_st = 0; m_wc = 0; m_lvl = 0; m_pend = 0;
                m_run = '{0, 0, 0};
            end else if (m_st == 0) begin
                m_st = 1; m_wc = 0;
            end else begin
                m_rise = 0;
                for (int i = 0; i < 3; i++) begin
                    if (m_s2[i] != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            m_lvl[i] = ~m_lvl[i];
                            m_run[i] = 0;
                            if (m_lvl[i]) m_rise[i] = 1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                if (m_st == 1) begin
                    if (m_wc == WARM - 1) m_st = 2;
                    else m_wc++;
                end else begin
                    m_pend = ((m_pend != 0 && motion_ready) ? 3'b000 : m_pend) | m_rise;
                end
            end
            m_s2 = m_s1;
            m_s1 = {pir_sensor_3, pir_sensor_2, pir_sensor_1};
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            int exp_lvl;
            exp_lvl = (m_st == 2) ? int'(m_lvl) : 0;
            chk("m_armed", int'(armed), int'(m_st == 2));
            chk("m_valid", int'(motion_valid), int'(m_pend != 0));
            chk("m_zone", int'(motion_zone), int'(m_pend));
            chk("m_level", int'(motion_level), exp_lvl);
            chk("m_count", int'(zone_count), $countones(exp_lvl));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_s(input logic [2:0] v);
        {pir_sensor_3, pir_sensor_2, pir_sensor_1} = v;
    endtask

    task automatic all_zero(input string name);
        chk({name, "_valid"}, int'(motion_valid), 0);
        chk({name, "_zone"}, int'(motion_zone), 0);
        chk({name, "_level"}, int'(motion_level), 0);
        chk({name, "_count"}, int'(zone_count), 0);
        chk({name, "_armed"}, int'(armed), 0);
    endtask

    initial begin
        rst_n = 0; turn = 1; motion_ready = 0;
        set_s(3'b111);

        // 1: reset with everything asserted, then arm 9 edges after release
        for (int i = 0; i < 3; i++) begin
            tick(1);
            all_zero("rst");
        end
        rst_n = 1;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            chk("arm_lat", int'(armed), int'(i == 9));
        end
        chk("rst_lvl", int'(motion_level), 7);
        chk("rst_noevt", int'(motion_valid), 0);

        // 2: warm-up lockout with sensors 1 and 3 high from the turn-on edge
        turn = 0; set_s(3'b000);
        tick(4);
        all_zero("off");
        turn = 1; set_s(3'b101);
        tick(8);
        chk("wu_notyet", int'(armed), 0);
        tick(1);
        chk("wu_armed", int'(armed), 1);
        chk("wu_lvl", int'(motion_level), 5);
        chk("wu_count", int'(zone_count), 2);
        tick(5);
        chk("wu_noevt", int'(motion_valid), 0);

        // 3: 3-cycle glitch rejected, held input accepted at k+5
        set_s(3'b111);
        tick(3);
        set_s(3'b101);
        tick(8);
        chk("gl_lvl", int'(motion_level), 5);
        chk("gl_valid", int'(motion_valid), 0);
        set_s(3'b111);
        tick(5);
        chk("hold_k4", int'(motion_level), 5);
        tick(1);
        chk("hold_lvl", int'(motion_level), 2 | 5);
        chk("hold_zone", int'(motion_zone), 2);
        chk("hold_valid", int'(motion_valid), 1);
        tick(6);
        chk("hold_keep", int'(motion_zone), 2);

        // 4: accumulate two zones with ready low, then one-cycle ack
        motion_ready = 1;
        tick(1);
        motion_ready = 0;
        chk("ack0_valid", int'(motion_valid), 0);
        set_s(3'b000);
        tick(8);
        chk("fall_lvl", int'(motion_level), 0);
        chk("fall_noevt", int'(motion_valid), 0);
        set_s(3'b001);
        tick(10);
        set_s(3'b101);
        tick(6);
        chk("acc_zone", int'(motion_zone), 5);
        chk("acc_count", int'(zone_count), 2);
        motion_ready = 1;
        tick(1);
        motion_ready = 0;
        chk("acc_ack", int'(motion_valid), 0);
        chk("acc_zone0", int'(motion_zone), 0);

        // 5: sensor 2 rise lands on the ack edge
        set_s(3'b100);
        tick(8);
        set_s(3'b101);
        tick(6);
        chk("s5_pre", int'(motion_zone), 1);
        set_s(3'b111);
        tick(5);
        chk("s5_before", int'(motion_zone), 1);
        motion_ready = 1;
        tick(1);
        motion_ready = 0;
        chk("s5_zone", int'(motion_zone), 2);
        chk("s5_valid", int'(motion_valid), 1);
        chk("s5_count", int'(zone_count), 3);

        // 6: one-cycle enable drop, full re-warm-up, no stale events
        turn = 0;
        tick(1);
        all_zero("drop");
        turn = 1;
        tick(8);
        chk("rw_notyet", int'(armed), 0);
        tick(1);
        chk("rw_armed", int'(armed), 1);
        chk("rw_lvl", int'(motion_level), 7);
        tick(4);
        chk("rw_noevt", int'(motion_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
